// File: rtl/ram_dump_tx_if.sv
//------------------------------------------------------------------------------
// Module : ram_dump_tx_if
// Brief  : Control, RAM read port and serial status bundle of ram_dump_tx.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ram_dump_tx_if #(
  parameter int AW = 17
);
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [31:0]   word_count_i;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic [31:0]   mem_rd_data_i;
  logic          uart_tx_o;
  logic          busy_o;
  logic          done_o;

  // master: host side plus RAM data return; slave: the dump engine
  modport master (
    output start_i, base_addr_i, word_count_i, mem_rd_data_i,
    input  mem_rd_en_o, mem_rd_addr_o, uart_tx_o, busy_o, done_o
  );

  modport slave (
    input  start_i, base_addr_i, word_count_i, mem_rd_data_i,
    output mem_rd_en_o, mem_rd_addr_o, uart_tx_o, busy_o, done_o
  );
endinterface

`default_nettype wire

// File: rtl/ram_dump_tx.sv
//------------------------------------------------------------------------------
// Module : ram_dump_tx
// Brief  : UART readback of a RAM block framed as "TEKNOFEST", count, words.
//          Optional macro RAM_DUMP_CHECKSUM_EN appends a 32-bit sum trailer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_dump_tx #(
  parameter int CPU_CLK   = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int RAM_DEPTH = 131072
) (
  input wire logic     clk_i,
  input wire logic     rst_ni,
  ram_dump_tx_if.slave bus
);

  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  localparam int AW  = clogb2(RAM_DEPTH - 1);
  localparam int DIV = CPU_CLK / BAUD_RATE;
  localparam int BW  = clogb2(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LENGTH, S_FETCH, S_LATCH, S_SEND, S_CSUM, S_FINISH
  } state_t;

`ifdef RAM_DUMP_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_FINISH;
`endif

  state_t          state, state_n, sel_state;
  logic [3:0]      idx, idx_n, sel_idx, last_idx;
  logic [AW-1:0]   addr;
  logic [31:0]     count, sent, word, trailer;
  logic            load, accept, latch, advance, rd_en, byte_end;
  logic [7:0]      byte_val;
  logic [8:0]      frame;
  logic [3:0]      bit_cnt;
  logic [BW-1:0]   baud_cnt;
  logic            tx_busy, tx;

  function automatic logic [7:0] header_byte(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h54;
      4'd1:    return 8'h45;
      4'd2:    return 8'h4B;
      4'd3:    return 8'h4E;
      4'd4:    return 8'h4F;
      4'd5:    return 8'h46;
      4'd6:    return 8'h45;
      4'd7:    return 8'h53;
      default: return 8'h54;
    endcase
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[31:24];
      2'd1:    return v[23:16];
      2'd2:    return v[15:8];
      default: return v[7:0];
    endcase
  endfunction

  assign byte_end = tx_busy && (baud_cnt == BW'(DIV - 1)) && (bit_cnt == 4'd9);
  assign last_idx = (state == S_HEADER) ? 4'd8 : 4'd3;

  // The next frame is loaded on the last stop-bit cycle so bytes run gapless
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    load      = 1'b0;
    sel_state = state;
    sel_idx   = idx;
    accept    = 1'b0;
    latch     = 1'b0;
    advance   = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          accept  = 1'b1;
          state_n = S_HEADER;
          idx_n   = 4'd0;
        end
      end
      S_HEADER, S_LENGTH, S_SEND, S_CSUM: begin
        if (!tx_busy) begin
          load = 1'b1;
        end else if (byte_end) begin
          if (idx != last_idx) begin
            idx_n   = idx + 4'd1;
            load    = 1'b1;
            sel_idx = idx_n;
          end else begin
            idx_n = 4'd0;
            case (state)
              S_HEADER: state_n = S_LENGTH;
              S_LENGTH: state_n = (count == 32'd0) ? S_TAIL : S_FETCH;
              S_SEND: begin
                advance = 1'b1;
                state_n = (sent + 32'd1 == count) ? S_TAIL : S_FETCH;
              end
              default:  state_n = S_FINISH;
            endcase
            load      = (state_n == S_LENGTH) || (state_n == S_CSUM);
            sel_state = state_n;
            sel_idx   = 4'd0;
          end
        end
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_n = S_LATCH;
      end
      S_LATCH: begin
        latch   = 1'b1;
        state_n = S_SEND;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    byte_val = 8'h00;
    case (sel_state)
      S_HEADER: byte_val = header_byte(sel_idx);
      S_LENGTH: byte_val = word_byte(count, sel_idx[1:0]);
      S_SEND:   byte_val = word_byte(word, sel_idx[1:0]);
      S_CSUM:   byte_val = word_byte(trailer, sel_idx[1:0]);
      default:  byte_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      idx   <= 4'd0;
      addr  <= '0;
      count <= 32'd0;
      sent  <= 32'd0;
      word  <= 32'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (accept) begin
        addr  <= bus.base_addr_i;
        count <= bus.word_count_i;
        sent  <= 32'd0;
      end
      if (latch) word <= bus.mem_rd_data_i;
      if (advance) begin
        addr <= (addr == AW'(RAM_DEPTH - 1)) ? '0 : addr + 1'b1;
        sent <= sent + 32'd1;
      end
    end
  end

`ifdef RAM_DUMP_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)     csum <= 32'd0;
    else if (accept) csum <= 32'd0;
    else if (latch)  csum <= csum + bus.mem_rd_data_i;
  end

  assign trailer = csum;
`else
  assign trailer = 32'd0;
`endif

  // frame holds data bits then the stop bit; the start bit is driven at load
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      frame    <= 9'd0;
      bit_cnt  <= 4'd0;
      baud_cnt <= '0;
    end else if (load) begin
      tx       <= 1'b0;
      tx_busy  <= 1'b1;
      frame    <= {1'b1, byte_val};
      bit_cnt  <= 4'd0;
      baud_cnt <= '0;
    end else if (tx_busy) begin
      if (baud_cnt == BW'(DIV - 1)) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          tx_busy <= 1'b0;
          tx      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= frame[0];
          frame   <= {1'b1, frame[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  assign bus.mem_rd_en_o   = rd_en;
  assign bus.mem_rd_addr_o = addr;
  assign bus.uart_tx_o     = tx;
  assign bus.busy_o        = (state != S_IDLE) && (state != S_FINISH);
  assign bus.done_o        = (state == S_FINISH);

endmodule

`default_nettype wire

// File: tb/tb_ram_dump_tx.sv
//------------------------------------------------------------------------------
// Module : tb_ram_dump_tx
// Brief  : Scoreboard bench for ram_dump_tx: reference stream model, UART
//          decoder, read-strobe and done monitors.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_dump_tx;
  localparam int CPU_CLK   = 40;
  localparam int BAUD_RATE = 10;
  localparam int DIV       = CPU_CLK / BAUD_RATE;
  localparam int RAM_DEPTH = 64;
  localparam int AW        = 6;
`ifdef RAM_DUMP_CHECKSUM_EN
  localparam int TRAIL = 4;
`else
  localparam int TRAIL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_dump_tx_if #(.AW(AW)) bus ();

  ram_dump_tx #(
    .CPU_CLK  (CPU_CLK),
    .BAUD_RATE(BAUD_RATE),
    .RAM_DEPTH(RAM_DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int exp_done = 0;
  logic [7:0]    exp_bytes[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   mem[RAM_DEPTH];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected none", name, act);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.mem_rd_en_o) bus.mem_rd_data_i <= mem[bus.mem_rd_addr_o];
  end

  // UART decoder sampling mid-bit on the falling clock edge
  int rx_cnt = 0;
  bit rx_act = 0;
  logic [7:0] rx_byte;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (bus.uart_tx_o === 1'b0) begin
        rx_act = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV == DIV / 2) begin
        if (rx_cnt / DIV >= 1 && rx_cnt / DIV <= 8) begin
          rx_byte[rx_cnt / DIV - 1] = bus.uart_tx_o;
        end else if (rx_cnt / DIV == 9) begin
          check("stop_bit", 64'(bus.uart_tx_o), 64'd1);
          if (exp_bytes.size() == 0) flag("unexpected_byte", 64'(rx_byte));
          else check("rx_byte", 64'(rx_byte), 64'(exp_bytes.pop_front()));
          rx_act = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.mem_rd_en_o === 1'b1) begin
      if (exp_addr.size() == 0) flag("unexpected_read", 64'(bus.mem_rd_addr_o));
      else check("rd_addr", 64'(bus.mem_rd_addr_o), 64'(exp_addr.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.done_o === 1'b1) begin
      done_cyc = cyc;
      if (exp_done == 0) begin
        flag("unexpected_done", 64'd1);
      end else begin
        exp_done--;
        check("done_bytes_left", 64'(exp_bytes.size()), 64'd0);
        check("done_reads_left", 64'(exp_addr.size()), 64'd0);
        check("busy_at_done", 64'(bus.busy_o), 64'd0);
      end
    end
  end

  // Reference: the whole expected stream follows from base, count and RAM
  task automatic start_job(input logic [AW-1:0] base, input logic [31:0] cnt, input bit expect_it);
    logic [31:0]   sum;
    logic [31:0]   w;
    logic [AW-1:0] a;
    logic [7:0]    hdr[9];
    hdr = '{8'h54, 8'h45, 8'h4B, 8'h4E, 8'h4F, 8'h46, 8'h45, 8'h53, 8'h54};
    sum = 32'd0;
    if (expect_it) begin
      foreach (hdr[i]) exp_bytes.push_back(hdr[i]);
      for (int s = 24; s >= 0; s -= 8) exp_bytes.push_back(8'(cnt >> s));
      for (int i = 0; i < int'(cnt); i++) begin
        a = AW'((int'(base) + i) % RAM_DEPTH);
        exp_addr.push_back(a);
        w = mem[a];
        for (int s = 24; s >= 0; s -= 8) exp_bytes.push_back(8'(w >> s));
        sum = sum + w;
      end
`ifdef RAM_DUMP_CHECKSUM_EN
      for (int s = 24; s >= 0; s -= 8) exp_bytes.push_back(8'(sum >> s));
`endif
      exp_done++;
    end
    bus.base_addr_i  = base;
    bus.word_count_i = cnt;
    bus.start_i      = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && exp_done > 0; i++) @(posedge clk);
    #1;
    if (exp_done > 0) flag("done_timeout", 64'(exp_done));
    repeat (3) @(posedge clk);
    #1;
    check("busy_after_done", 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i      = 1'b0;
    bus.base_addr_i  = '0;
    bus.word_count_i = 32'd0;
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = $urandom;
    mem[16] = 32'hDEADBEEF;
    mem[17] = 32'h01020304;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 64'(bus.uart_tx_o), 64'd1);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_rd_en", 64'(bus.mem_rd_en_o), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // count = 0: header and length only, done after 13 (or 17) byte times
    start_job('0, 32'd0, 1);
    check("busy_after_start", 64'(bus.busy_o), 64'd1);
    wait_done(60 * (13 + TRAIL) + 100);
    check("done_latency_ok", 64'((done_cyc - start_cyc >= (13 + TRAIL) * 10 * DIV) &&
                                 (done_cyc - start_cyc <= (13 + TRAIL) * 10 * DIV + 4)), 64'd1);

    start_job(AW'(16), 32'd2, 1);
    wait_done(60 * (21 + TRAIL) + 100);

    start_job(AW'(RAM_DEPTH - 1), 32'd2, 1);
    wait_done(60 * (21 + TRAIL) + 100);

    for (int j = 0; j < 4; j++) begin
      logic [31:0] c;
      c = 32'($urandom_range(1, 3));
      start_job(AW'($urandom_range(0, RAM_DEPTH - 1)), c, 1);
      wait_done(60 * (13 + 4 * int'(c) + TRAIL) + 100);
    end

    // start while busy must be ignored
    start_job(AW'(5), 32'd2, 1);
    repeat (200) @(posedge clk);
    #1;
    start_job(AW'(40), 32'd3, 0);
    wait_done(60 * (21 + TRAIL) + 100);
    repeat (100) @(posedge clk);
    #1;

    // reset in the middle of a data bit of the first word
    start_job(AW'(30), 32'd3, 1);
    for (int i = 0; i < 2000 && exp_addr.size() == 3; i++) @(posedge clk);
    repeat (45) @(posedge clk);
    for (int i = 0; i < 40 && bus.uart_tx_o !== 1'b0; i++) @(posedge clk);
    #1;
    check("tx_low_before_rst", 64'(bus.uart_tx_o), 64'd0);
    rst_n = 1'b0;
    exp_bytes.delete();
    exp_addr.delete();
    exp_done = 0;
    @(posedge clk);
    #1;
    check("midrst_tx", 64'(bus.uart_tx_o), 64'd1);
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_done", 64'(bus.done_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    start_job(AW'(30), 32'd3, 1);
    wait_done(60 * (25 + TRAIL) + 100);

    check("final_bytes_left", 64'(exp_bytes.size()), 64'd0);
    check("final_reads_left", 64'(exp_addr.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
